// File: rtl/rle_decoder.sv
// Run-length decoder: expands (character, extra-repeat count) pairs into a
// single-character stream, flagging illegal characters and the null terminator.
module rle_decoder #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TOT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [6:0]       in_char,
    input  logic [CNT_W-1:0] in_count,
    output logic             in_ready,
    output logic             out_valid,
    output logic [6:0]       out_char,
    input  logic             out_ready,
    output logic             done,
    output logic             error,
    output logic [TOT_W-1:0] total_out
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [6:0]       char_q, char_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [TOT_W-1:0] total_q, total_d;

    logic in_xfer, out_xfer, char_legal, char_null, run_last;

    assign char_legal = (in_char >= 7'd32) && (in_char <= 7'd126);
    assign char_null  = (in_char == 7'd0);
    assign run_last   = (rem_q == '0);

    // A new pair is only taken in EMIT when the last character of the current
    // run leaves this cycle, so the next run starts without a bubble.
    assign in_ready  = (state_q == IDLE) || (run_last && out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = (state_q == EMIT);
    assign out_xfer  = out_valid && out_ready;
    assign out_char  = char_q;
    assign done      = done_q;
    assign error     = error_q;
    assign total_out = total_q;

    always_comb begin
        state_d = state_q;
        char_d  = char_q;
        rem_d   = rem_q;
        done_d  = in_xfer && char_null;
        error_d = error_q || (in_xfer && !char_legal && !char_null);
        total_d = total_q;
        if (out_xfer && (total_q != '1)) begin
            total_d = total_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (in_xfer && char_legal) begin
                    char_d  = in_char;
                    rem_d   = in_count;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_xfer) begin
                    if (!run_last) begin
                        rem_d = rem_q - 1'b1;
                    end else if (in_xfer && char_legal) begin
                        char_d = in_char;
                        rem_d  = in_count;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            char_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            char_q  <= char_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            error_q <= error_d;
            total_q <= total_d;
        end
    end

endmodule

// File: tb/tb_rle_decoder.sv
// Directed bench for rle_decoder: runs, stalls, maximum run, illegal and null
// pairs, and asynchronous reset in the middle of a run.
module tb_rle_decoder;

    localparam int CNT_W = 8;
    localparam int TOT_W = 16;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [6:0]       in_char = '0;
    logic [CNT_W-1:0] in_count = '0;
    logic             in_ready;
    logic             out_valid;
    logic [6:0]       out_char;
    logic             out_ready = 1'b1;
    logic             done;
    logic             error;
    logic [TOT_W-1:0] total_out;

    int passed = 0;
    int checks = 0;

    // Pending pairs, per-cycle out_ready pattern, and per-cycle observations.
    int   pc_q[$];
    int   pn_q[$];
    bit   pat_q[$];
    logic [6:0] xc[$];
    logic cv[$];
    logic [6:0] cc[$];
    logic cir[$];
    logic cdone[$];
    logic cerr[$];

    always #5 clock = ~clock;

    rle_decoder #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_char(in_char), .in_count(in_count), .in_ready(in_ready),
        .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready),
        .done(done), .error(error), .total_out(total_out)
    );

    // Drives queued pairs and the out_ready pattern for n cycles, recording
    // what the DUT shows in each cycle. Entered and left at posedge + 1.
    task automatic run(input int n);
        xc.delete(); cv.delete(); cc.delete(); cir.delete(); cdone.delete(); cerr.delete();
        for (int i = 0; i < n; i++) begin
            in_valid  = (pc_q.size() > 0);
            in_char   = (pc_q.size() > 0) ? 7'(pc_q[0]) : 7'd0;
            in_count  = (pn_q.size() > 0) ? 8'(pn_q[0]) : 8'd0;
            out_ready = (i < pat_q.size()) ? pat_q[i] : 1'b1;
            #1;
            cv.push_back(out_valid);
            cc.push_back(out_char);
            cir.push_back(in_ready);
            cdone.push_back(done);
            cerr.push_back(error);
            if (out_valid && out_ready) xc.push_back(out_char);
            if (in_valid && in_ready) begin
                void'(pc_q.pop_front());
                void'(pn_q.pop_front());
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        pat_q.delete();
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
        checks++; if (out_char !== 7'd0) $display("FAIL reset_out_char got=%h exp=00", out_char); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
        checks++; if (done !== 1'b0 || error !== 1'b0) $display("FAIL reset_flags got=%b%b exp=00", done, error); else passed++;
        checks++; if (total_out !== 16'd0) $display("FAIL reset_total got=%0d exp=0", total_out); else passed++;
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        string exp = "AAABCC";
        pc_q = '{65, 66, 67}; pn_q = '{2, 0, 1};
        run(9);
        checks++; if (xc.size() != 6) $display("FAIL basic_count got=%0d exp=6", xc.size()); else passed++;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (cv[i+1] !== 1'b1 || cc[i+1] !== 7'(exp[i]))
                $display("FAIL basic_char[%0d] got=%b/%h exp=1/%h", i, cv[i+1], cc[i+1], 7'(exp[i]));
            else passed++;
        end
        checks++; if (cir[3] !== 1'b1) $display("FAIL basic_ready_lastA got=%b exp=1", cir[3]); else passed++;
        checks++; if (cir[4] !== 1'b1) $display("FAIL basic_ready_B got=%b exp=1", cir[4]); else passed++;
        checks++; if (cir[2] !== 1'b0) $display("FAIL basic_ready_midA got=%b exp=0", cir[2]); else passed++;
        checks++; if (cv[7] !== 1'b0) $display("FAIL basic_idle got=%b exp=0", cv[7]); else passed++;
        checks++; if (total_out !== 16'd6) $display("FAIL basic_total got=%0d exp=6", total_out); else passed++;
    endtask

    task automatic test_stall;
        pc_q = '{120}; pn_q = '{3};
        pat_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run(10);
        checks++; if (xc.size() != 4) $display("FAIL stall_count got=%0d exp=4", xc.size()); else passed++;
        for (int i = 0; i < xc.size(); i++) begin
            checks++; if (xc[i] !== 7'h78) $display("FAIL stall_char[%0d] got=%h exp=78", i, xc[i]); else passed++;
        end
        for (int i = 2; i <= 6; i += 4) begin
            checks++;
            if (cv[i] !== 1'b1 || cc[i] !== 7'h78) $display("FAIL stall_hold[%0d] got=%b/%h exp=1/78", i, cv[i], cc[i]);
            else passed++;
        end
        checks++; if (cv[3] !== 1'b1 || cc[3] !== 7'h78) $display("FAIL stall_hold[3] got=%b/%h exp=1/78", cv[3], cc[3]); else passed++;
        for (int i = 1; i <= 6; i++) begin
            checks++; if (cir[i] !== 1'b0) $display("FAIL stall_ready_low[%0d] got=%b exp=0", i, cir[i]); else passed++;
        end
        checks++; if (cir[7] !== 1'b1) $display("FAIL stall_ready_last got=%b exp=1", cir[7]); else passed++;
        checks++; if (cv[8] !== 1'b0) $display("FAIL stall_idle got=%b exp=0", cv[8]); else passed++;
        checks++; if (total_out !== 16'd10) $display("FAIL stall_total got=%0d exp=10", total_out); else passed++;
    endtask

    task automatic test_max_run;
        int bad = 0;
        pc_q = '{90}; pn_q = '{255};
        run(260);
        checks++; if (xc.size() != 256) $display("FAIL max_count got=%0d exp=256", xc.size()); else passed++;
        for (int i = 0; i < xc.size(); i++) if (xc[i] !== 7'h5A) bad++;
        checks++; if (bad != 0) $display("FAIL max_chars got=%0d_bad exp=0_bad", bad); else passed++;
        checks++; if (cir[255] !== 1'b0) $display("FAIL max_ready_255 got=%b exp=0", cir[255]); else passed++;
        checks++; if (cir[256] !== 1'b1) $display("FAIL max_ready_256 got=%b exp=1", cir[256]); else passed++;
        checks++; if (cv[257] !== 1'b0) $display("FAIL max_idle got=%b exp=0", cv[257]); else passed++;
        checks++; if (total_out !== 16'd266) $display("FAIL max_total got=%0d exp=266", total_out); else passed++;
    endtask

    task automatic test_error;
        pc_q = '{5, 81}; pn_q = '{7, 0};
        run(6);
        checks++; if (cerr[0] !== 1'b0) $display("FAIL err_before got=%b exp=0", cerr[0]); else passed++;
        checks++; if (cerr[1] !== 1'b1) $display("FAIL err_next got=%b exp=1", cerr[1]); else passed++;
        checks++; if (cerr[5] !== 1'b1) $display("FAIL err_sticky got=%b exp=1", cerr[5]); else passed++;
        checks++; if (cv[1] !== 1'b0) $display("FAIL err_no_output got=%b exp=0", cv[1]); else passed++;
        checks++;
        if (xc.size() != 1 || xc[0] !== 7'h51) $display("FAIL err_Q got=%0d/%h exp=1/51", xc.size(), xc[0]);
        else passed++;
        checks++; if (total_out !== 16'd267) $display("FAIL err_total got=%0d exp=267", total_out); else passed++;
    endtask

    task automatic test_done;
        int pulses = 0;
        pc_q = '{72, 0}; pn_q = '{1, 9};
        run(7);
        checks++;
        if (xc.size() != 2 || xc[0] !== 7'h48 || xc[1] !== 7'h48)
            $display("FAIL done_HH got=%0d_chars exp=2_chars_48", xc.size());
        else passed++;
        checks++; if (cdone[3] !== 1'b1) $display("FAIL done_pulse got=%b exp=1", cdone[3]); else passed++;
        for (int i = 0; i < 7; i++) if (cdone[i] === 1'b1) pulses++;
        checks++; if (pulses != 1) $display("FAIL done_width got=%0d exp=1", pulses); else passed++;
        for (int i = 3; i < 7; i++) begin
            checks++; if (cv[i] !== 1'b0) $display("FAIL done_no_extra[%0d] got=%b exp=0", i, cv[i]); else passed++;
        end
        checks++; if (total_out !== 16'd269) $display("FAIL done_total got=%0d exp=269", total_out); else passed++;
    endtask

    task automatic test_reset_mid_run;
        pc_q = '{82}; pn_q = '{5};
        run(2);
        checks++;
        if (out_valid !== 1'b1 || out_char !== 7'h52) $display("FAIL rst_pre got=%b/%h exp=1/52", out_valid, out_char);
        else passed++;
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else passed++;
        checks++; if (total_out !== 16'd0) $display("FAIL rst_total got=%0d exp=0", total_out); else passed++;
        checks++; if (error !== 1'b0) $display("FAIL rst_error got=%b exp=0", error); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else passed++;
        #3 reset_n = 1'b1;
        @(posedge clock);
        #1;
        pc_q = '{83}; pn_q = '{0};
        run(5);
        checks++;
        if (xc.size() != 1 || xc[0] !== 7'h53) $display("FAIL rst_S got=%0d/%h exp=1/53", xc.size(), xc[0]);
        else passed++;
        checks++; if (total_out !== 16'd1) $display("FAIL rst_S_total got=%0d exp=1", total_out); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_max_run();
        test_error();
        test_done();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
